// File: rtl/serial_tx_queue_if.sv
// Handshake and status bundle for serial_tx_queue: a parallel word goes in,
// and the serial bit stream plus queue status come out.
interface serial_tx_queue_if #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 4
);
    logic [WIDTH-1:0]           data;
    logic                       data_valid;
    logic                       data_accept;
    logic                       serial_out;
    logic                       serial_done;
    logic                       busy;
    logic [$clog2(DEPTH+1)-1:0] fifo_count;

    modport master (
        output data,
        output data_valid,
        input  data_accept,
        input  serial_out,
        input  serial_done,
        input  busy,
        input  fifo_count
    );

    modport slave (
        input  data,
        input  data_valid,
        output data_accept,
        output serial_out,
        output serial_done,
        output busy,
        output fifo_count
    );
endinterface

// File: rtl/serial_tx_queue.sv
// Small word FIFO feeding an LSB-first serializer; each frame ends with a
// one-cycle serial_done strobe, and back-to-back frames repeat every WIDTH+1 cycles.
module serial_tx_queue #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 4
) (
    input  logic              fast_clk,
    input  logic              reset,
    serial_tx_queue_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             serial_out_q, serial_out_d;
    logic             serial_done_q, serial_done_d;
    logic             busy_q, busy_d;
    logic             push;
    logic             pop;

    // Accept depends only on the registered count, so a slot freed by a
    // same-cycle pop is not offered until the following cycle.
    assign bus.data_accept = (count_q < CNT_W'(DEPTH));
    assign push            = bus.data_valid && bus.data_accept;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        pop       = 1'b0;

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop       = 1'b1;
                    shift_d   = mem_q[rd_ptr_q];
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                shift_d   = shift_q >> 1;
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == BIT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (count_q != '0) begin
                    pop       = 1'b1;
                    shift_d   = mem_q[rd_ptr_q];
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

        // Outputs are derived from next-state values so they can be registered
        // without adding a cycle of latency.
        serial_out_d  = (state_d == SHIFT) && shift_d[0];
        serial_done_d = (state_d == DONE);
        busy_d        = (state_d != IDLE);
    end

    always_ff @(posedge fast_clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            serial_out_q  <= 1'b0;
            serial_done_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            serial_out_q  <= serial_out_d;
            serial_done_q <= serial_done_d;
            busy_q        <= busy_d;
        end
    end

    // Storage needs no reset: the pointers and count define which slots are live.
    always_ff @(posedge fast_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.data;
        end
    end

    assign bus.serial_out  = serial_out_q;
    assign bus.serial_done = serial_done_q;
    assign bus.busy        = busy_q;
    assign bus.fifo_count  = count_q;
endmodule

// File: tb/tb_serial_tx_queue.sv
// Scoreboard bench for serial_tx_queue: a 25-bit/4-deep instance and an
// 8-bit/2-deep instance, with collector-style monitors rebuilding each frame.
module tb_serial_tx_queue;
    logic fast_clk;
    logic reset;
    int   checks;
    int   errors;
    int   cycle;

    serial_tx_queue_if #(.WIDTH(25), .DEPTH(4)) a_if ();
    serial_tx_queue_if #(.WIDTH(8),  .DEPTH(2)) b_if ();

    serial_tx_queue #(.WIDTH(25), .DEPTH(4)) dut_a (
        .fast_clk (fast_clk),
        .reset    (reset),
        .bus      (a_if)
    );

    serial_tx_queue #(.WIDTH(8), .DEPTH(2)) dut_b (
        .fast_clk (fast_clk),
        .reset    (reset),
        .bus      (b_if)
    );

    logic [24:0] a_exp_q [$];
    logic [7:0]  b_exp_q [$];
    int          a_gap_q [$];
    int          b_gap_q [$];
    int          a_last_done, b_last_done, a_last_push;
    bit          a_have_last, b_have_last;
    logic [24:0] a_bits;
    logic [7:0]  b_bits;
    int          a_nbits, b_nbits;
    bit          a_prev_done;
    logic [24:0] ovf_words [6];
    bit          ovf_acc [6];

    initial begin
        fast_clk = 1'b0;
        forever #5 fast_clk = ~fast_clk;
    end

    always @(posedge fast_clk) cycle++;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d",
                     name, actual, expected, cycle);
        end
    endtask

    // Drives one word for one cycle; called right after a falling edge.
    task automatic applyStimulus(input logic [24:0] word, input bit exp_accept);
        a_if.data       = word;
        a_if.data_valid = 1'b1;
        checkOutput("a_data_accept", 32'(a_if.data_accept), 32'(exp_accept));
        if (exp_accept) a_exp_q.push_back(word);
        a_last_push = cycle + 1;
        @(negedge fast_clk);
        a_if.data_valid = 1'b0;
    endtask

    task automatic applyStimulusB(input logic [7:0] word, input bit exp_accept);
        b_if.data       = word;
        b_if.data_valid = 1'b1;
        checkOutput("b_data_accept", 32'(b_if.data_accept), 32'(exp_accept));
        if (exp_accept) b_exp_q.push_back(word);
        @(negedge fast_clk);
        b_if.data_valid = 1'b0;
    endtask

    task automatic waitDoneA(input int budget);
        int n = 0;
        while (!a_if.serial_done && n < budget) begin
            @(negedge fast_clk);
            n++;
        end
        checkOutput("a_wait_done", 32'(a_if.serial_done), 1);
    endtask

    task automatic waitDrainA(input int budget);
        int n = 0;
        while ((a_if.busy || a_exp_q.size() != 0) && n < budget) begin
            @(negedge fast_clk);
            n++;
        end
        checkOutput("a_drain_queue", a_exp_q.size(), 0);
        checkOutput("a_drain_busy", 32'(a_if.busy), 0);
    endtask

    task automatic waitDrainB(input int budget);
        int n = 0;
        while ((b_if.busy || b_exp_q.size() != 0) && n < budget) begin
            @(negedge fast_clk);
            n++;
        end
        checkOutput("b_drain_queue", b_exp_q.size(), 0);
        checkOutput("b_drain_busy", 32'(b_if.busy), 0);
    endtask

    // Collector model for instance A: gathers SHIFT bits LSB first and
    // checks each completed frame against the scoreboard.
    always @(negedge fast_clk) begin
        if (!reset) begin
            a_nbits     = 0;
            a_prev_done = 1'b0;
            checkOutput("a_reset_no_done", 32'(a_if.serial_done), 0);
        end else begin
            if (a_if.serial_done) begin
                checkOutput("a_done_one_cycle", 32'(a_prev_done), 0);
                checkOutput("a_done_serial_out", 32'(a_if.serial_out), 0);
                checkOutput("a_frame_bits", a_nbits, 25);
                checkOutput("a_frame_expected", 32'(a_exp_q.size() != 0), 1);
                if (a_exp_q.size() != 0) begin
                    checkOutput("a_frame_word", 32'(a_bits), 32'(a_exp_q.pop_front()));
                end
                if (a_have_last) a_gap_q.push_back(cycle - a_last_done);
                a_have_last = 1'b1;
                a_last_done = cycle;
                a_nbits     = 0;
            end else if (a_if.busy) begin
                a_bits = {a_if.serial_out, a_bits[24:1]};
                a_nbits++;
            end else begin
                checkOutput("a_idle_serial_out", 32'(a_if.serial_out), 0);
            end
            a_prev_done = a_if.serial_done;
        end
    end

    always @(negedge fast_clk) begin
        if (!reset) begin
            b_nbits = 0;
        end else if (b_if.serial_done) begin
            checkOutput("b_frame_bits", b_nbits, 8);
            checkOutput("b_frame_expected", 32'(b_exp_q.size() != 0), 1);
            if (b_exp_q.size() != 0) begin
                checkOutput("b_frame_word", 32'(b_bits), 32'(b_exp_q.pop_front()));
            end
            if (b_have_last) b_gap_q.push_back(cycle - b_last_done);
            b_have_last = 1'b1;
            b_last_done = cycle;
            b_nbits     = 0;
        end else if (b_if.busy) begin
            b_bits = {b_if.serial_out, b_bits[7:1]};
            b_nbits++;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks          = 0;
        errors          = 0;
        cycle           = 0;
        reset           = 1'b0;
        a_if.data       = '0;
        a_if.data_valid = 1'b0;
        b_if.data       = '0;
        b_if.data_valid = 1'b0;
        ovf_words = '{25'd101, 25'd202, 25'd303, 25'd404, 25'd505, 25'd606};
        ovf_acc   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        repeat (2) @(negedge fast_clk);
        checkOutput("rst_serial_out", 32'(a_if.serial_out), 0);
        checkOutput("rst_busy", 32'(a_if.busy), 0);
        checkOutput("rst_data_accept", 32'(a_if.data_accept), 1);
        checkOutput("rst_fifo_count", 32'(a_if.fifo_count), 0);
        reset = 1'b1;
        @(negedge fast_clk);

        $display("[TB] single word 3461");
        applyStimulus(25'd3461, 1'b1);
        checkOutput("single_not_loaded_busy", 32'(a_if.busy), 0);
        checkOutput("single_count_after_push", 32'(a_if.fifo_count), 1);
        @(negedge fast_clk);
        checkOutput("single_first_busy", 32'(a_if.busy), 1);
        checkOutput("single_first_bit", 32'(a_if.serial_out), 1);
        checkOutput("single_count_after_load", 32'(a_if.fifo_count), 0);
        waitDoneA(40);
        @(negedge fast_clk);
        checkOutput("single_latency", a_last_done - a_last_push, 26);
        waitDrainA(20);

        $display("[TB] burst of four words");
        a_have_last = 1'b0;
        a_gap_q.delete();
        applyStimulus(25'h1FF_FFFF, 1'b1);
        applyStimulus(25'd0, 1'b1);
        applyStimulus(25'd69420, 1'b1);
        applyStimulus(25'd69, 1'b1);
        waitDrainA(200);
        checkOutput("burst_gap_count", a_gap_q.size(), 3);
        foreach (a_gap_q[i]) checkOutput("burst_gap", a_gap_q[i], 26);

        $display("[TB] overflow with six words");
        for (int i = 0; i < 6; i++) begin
            if (i == 5) checkOutput("ovf_full_count", 32'(a_if.fifo_count), 4);
            applyStimulus(ovf_words[i], ovf_acc[i]);
        end
        waitDrainA(300);

        $display("[TB] push and pop on the same edge");
        applyStimulus(25'h012_3456, 1'b1);
        applyStimulus(25'h1AB_CDEF, 1'b1);
        applyStimulus(25'h0F0_F0F0, 1'b1);
        waitDoneA(40);
        checkOutput("pushpop_count_before", 32'(a_if.fifo_count), 2);
        applyStimulus(25'h001_0203, 1'b1);
        checkOutput("pushpop_count_after", 32'(a_if.fifo_count), 2);
        checkOutput("pushpop_busy", 32'(a_if.busy), 1);
        waitDrainA(200);

        $display("[TB] reset in the middle of a frame");
        applyStimulus(25'h0AA_AAAA, 1'b1);
        applyStimulus(25'd777, 1'b1);
        applyStimulus(25'd888, 1'b1);
        repeat (10) @(negedge fast_clk);
        checkOutput("mid_count", 32'(a_if.fifo_count), 2);
        checkOutput("mid_busy", 32'(a_if.busy), 1);
        checkOutput("mid_bit11", 32'(a_if.serial_out), 1);
        #2 reset = 1'b0;
        a_exp_q.delete();
        #1;
        checkOutput("abort_serial_out", 32'(a_if.serial_out), 0);
        checkOutput("abort_busy", 32'(a_if.busy), 0);
        checkOutput("abort_done", 32'(a_if.serial_done), 0);
        checkOutput("abort_count", 32'(a_if.fifo_count), 0);
        checkOutput("abort_accept", 32'(a_if.data_accept), 1);
        repeat (3) @(negedge fast_clk);
        reset = 1'b1;
        @(negedge fast_clk);
        applyStimulus(25'd5, 1'b1);
        checkOutput("post_rst_not_loaded", 32'(a_if.busy), 0);
        @(negedge fast_clk);
        checkOutput("post_rst_first_bit", 32'(a_if.serial_out), 1);
        waitDoneA(40);
        @(negedge fast_clk);
        checkOutput("post_rst_latency", a_last_done - a_last_push, 26);
        waitDrainA(20);

        $display("[TB] WIDTH=8 DEPTH=2 instance");
        b_have_last = 1'b0;
        b_gap_q.delete();
        applyStimulusB(8'hA5, 1'b1);
        applyStimulusB(8'h3C, 1'b1);
        applyStimulusB(8'h81, 1'b1);
        checkOutput("b_full_count", 32'(b_if.fifo_count), 2);
        applyStimulusB(8'hFF, 1'b0);
        waitDrainB(100);
        checkOutput("b_gap_count", b_gap_q.size(), 2);
        foreach (b_gap_q[i]) checkOutput("b_gap", b_gap_q[i], 9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
